// File: rtl/ascon_engine_arbiter.sv
// Round-robin arbiter that shares one Ascon AEAD engine between two requesters.
// It latches the winning job, runs the engine handshake, checks decrypt tags and flushes a hung engine.
module ascon_engine_arbiter #(
    parameter int K       = 128,
    parameter int L       = 40,
    parameter int Y       = 40,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_mode,
    input  logic [2*K-1:0]   req_key,
    input  logic [255:0]     req_nonce,
    input  logic [2*L-1:0]   req_ad,
    input  logic [2*Y-1:0]   req_data,
    input  logic [255:0]     req_tag,
    output logic             eng_mode,
    output logic [K-1:0]     eng_key,
    output logic [127:0]     eng_nonce,
    output logic [L-1:0]     eng_ad,
    output logic [Y-1:0]     eng_data,
    output logic             eng_start,
    output logic             eng_flush,
    input  logic             eng_ready,
    input  logic [Y-1:0]     eng_data_out,
    input  logic [127:0]     eng_tag,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [Y-1:0]     rsp_data,
    output logic [127:0]     rsp_tag,
    output logic             rsp_auth_ok,
    output logic             rsp_timeout,
    output logic [15:0]      auth_fail_cnt
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RESPOND, RELEASE} state_t;

    state_t         state_q, state_d;
    logic           ptr_q, ptr_d;
    logic           owner_q, owner_d;
    logic           mode_q, mode_d;
    logic [K-1:0]   key_q, key_d;
    logic [127:0]   nonce_q, nonce_d;
    logic [L-1:0]   ad_q, ad_d;
    logic [Y-1:0]   data_q, data_d;
    logic [127:0]   etag_q, etag_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [Y-1:0]   rdata_q, rdata_d;
    logic [127:0]   rtag_q, rtag_d;
    logic           auth_q, auth_d;
    logic           tmo_q, tmo_d;
    logic [15:0]    fail_q, fail_d;
    logic           win;
    logic           auth_ok;

    // Sole requester wins; on contention the one the pointer did not last serve.
    assign win     = (req_valid == 2'b01) ? 1'b0 : (req_valid == 2'b10) ? 1'b1 : ~ptr_q;
    assign auth_ok = ~mode_q | (eng_tag == etag_q);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        mode_d    = mode_q;
        key_d     = key_q;
        nonce_d   = nonce_q;
        ad_d      = ad_q;
        data_d    = data_q;
        etag_d    = etag_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        rtag_d    = rtag_q;
        auth_d    = auth_q;
        tmo_d     = tmo_q;
        fail_d    = fail_q;
        req_ready = 2'b00;
        eng_start = 1'b0;
        eng_flush = 1'b0;
        rsp_valid = 2'b00;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[win] = 1'b1;
                    owner_d = win;
                    ptr_d   = win;
                    mode_d  = req_mode[win];
                    key_d   = win ? req_key[2*K-1:K]     : req_key[K-1:0];
                    nonce_d = win ? req_nonce[255:128]   : req_nonce[127:0];
                    ad_d    = win ? req_ad[2*L-1:L]      : req_ad[L-1:0];
                    data_d  = win ? req_data[2*Y-1:Y]    : req_data[Y-1:0];
                    etag_d  = win ? req_tag[255:128]     : req_tag[127:0];
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                eng_start = 1'b1;
                cnt_d     = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (eng_ready) begin
                    // Unauthenticated plaintext never leaves the block.
                    rdata_d = auth_ok ? eng_data_out : '0;
                    rtag_d  = eng_tag;
                    auth_d  = auth_ok;
                    tmo_d   = 1'b0;
                    if (!auth_ok && fail_q != 16'hFFFF)
                        fail_d = fail_q + 16'd1;
                    state_d = RESPOND;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    eng_flush = 1'b1;
                    rdata_d   = '0;
                    rtag_d    = '0;
                    auth_d    = 1'b0;
                    tmo_d     = 1'b1;
                    state_d   = RESPOND;
                end
            end
            RESPOND: begin
                rsp_valid[owner_q] = 1'b1;
                // A flushed engine is already idle, so it skips the release pulse.
                if (rsp_ready[owner_q])
                    state_d = tmo_q ? IDLE : RELEASE;
            end
            RELEASE: begin
                eng_start = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b1;
            owner_q <= 1'b0;
            mode_q  <= 1'b0;
            key_q   <= '0;
            nonce_q <= '0;
            ad_q    <= '0;
            data_q  <= '0;
            etag_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            rtag_q  <= '0;
            auth_q  <= 1'b0;
            tmo_q   <= 1'b0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            mode_q  <= mode_d;
            key_q   <= key_d;
            nonce_q <= nonce_d;
            ad_q    <= ad_d;
            data_q  <= data_d;
            etag_q  <= etag_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rtag_q  <= rtag_d;
            auth_q  <= auth_d;
            tmo_q   <= tmo_d;
            fail_q  <= fail_d;
        end
    end

    assign eng_mode      = mode_q;
    assign eng_key       = key_q;
    assign eng_nonce     = nonce_q;
    assign eng_ad        = ad_q;
    assign eng_data      = data_q;
    assign rsp_data      = rdata_q;
    assign rsp_tag       = rtag_q;
    assign rsp_auth_ok   = auth_q;
    assign rsp_timeout   = tmo_q;
    assign auth_fail_cnt = fail_q;
endmodule

// File: doc/ascon_engine_arbiter.md
Name: ascon_engine_arbiter

Overview:
- Shares one Ascon AEAD engine between two requesters.
- Engine runs encryption or decryption, selected per job.
- Round-robin arbitration; latches the winner's operands and sequences the engine start/ready/release protocol.
- Verifies the decryption tag, withholds unauthenticated plaintext, and recovers a hung engine via timeout flush.
- Sits between the host-facing job ports and the Ascon core.

Parameters:
K, 128, key width in bits
L, 40, associated-data width in bits
Y, 40, plaintext/ciphertext width in bits
TIMEOUT, 1023, max WAIT cycles before flush (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  2  job request per requester (bit i = requester i)
req_ready  out  2  grant/accept per requester
req_mode  in  2  per requester: 0 encrypt, 1 decrypt
req_key  in  2*K  keys, requester i at [i*K +: K]
req_nonce  in  2*128  nonces
req_ad  in  2*L  associated data
req_data  in  2*Y  plaintext (encrypt) or ciphertext (decrypt)
req_tag  in  2*128  expected tag (decrypt only)
eng_mode  out  1  latched mode to engine
eng_key  out  K  latched key
eng_nonce  out  128  latched nonce
eng_ad  out  L  latched associated data
eng_data  out  Y  latched data
eng_start  out  1  engine start/release pulse
eng_flush  out  1  one-cycle engine reset on timeout
eng_ready  in  1  engine done, held until next start
eng_data_out  in  Y  engine result text
eng_tag  in  128  engine computed tag
rsp_valid  out  2  response valid, owner bit only
rsp_ready  in  2  response accept per requester
rsp_data  out  Y  result text
rsp_tag  out  128  computed tag
rsp_auth_ok  out  1  1 = tag match (decrypt), always 1 for encrypt
rsp_timeout  out  1  job aborted by timeout
auth_fail_cnt  out  16  saturating count of decrypt tag mismatches

Behaviour:
- Reset (async): state IDLE, rr pointer=1 (requester 0 wins first), all outputs, latches and counters 0.
- States: IDLE, LAUNCH, WAIT, RESPOND, RELEASE.
- IDLE: if any req_valid, grant: sole valid requester, else the one not equal to pointer.
  - req_ready[w]=1 combinationally in that cycle only.
  - At the edge: latch operands, owner=w, pointer=w, go to LAUNCH. Never both req_ready bits high.
- LAUNCH: eng_start=1 exactly one cycle; clear wait counter; go to WAIT. eng_ready is ignored here.
- WAIT: counter increments each cycle.
  - If eng_ready: capture result, go to RESPOND. On a decrypt tag match, capture eng_data_out; on a mismatch, capture 0. Capture eng_tag as is.
  - auth_ok = (mode==0) | (eng_tag == latched expected tag).
  - Mismatch increments auth_fail_cnt, saturating at 0xFFFF.
  - Else if counter == TIMEOUT-1: eng_flush=1 one cycle; rsp_data=0, rsp_tag=0, auth_ok=0, timeout=1; go to RESPOND.
  - eng_ready takes precedence on the same cycle as the timeout.
- RESPOND: rsp_valid[owner]=1, response fields stable until rsp_ready[owner].
  - rsp_ready of the non-owner is ignored.
  - On handshake: go to RELEASE if not timed out, else to IDLE.
- RELEASE: eng_start=1 one cycle (returns engine DONE->IDLE); go to IDLE.
- New requests are not accepted outside IDLE. req_valid may drop without a grant; no state change.
- eng_* operand outputs hold the latched values from grant until the next grant.
- Latency, grant to rsp_valid: 2 + engine cycles (grant, LAUNCH, WAIT...).
- Reset mid-operation: immediate IDLE, no response issued; the in-flight job is lost; the engine is reset by system rst.

Test Plan:
- Req0 decrypt, expected tag == engine tag, engine ready after 30 WAIT cycles -> req_ready[0] one cycle; eng_start pulse at LAUNCH; rsp_valid[0] with rsp_data=eng_data_out; auth_ok=1; RELEASE eng_start pulse; back to IDLE.
- Req1 decrypt, tag differs in 1 bit -> rsp_data=0, rsp_tag=eng_tag, auth_ok=0, auth_fail_cnt 0->1. Encrypt job -> auth_ok=1, counter unchanged.
- Both req_valid held high for 4 jobs after reset -> grants 0,1,0,1; rsp_valid only on owner bit.
- TIMEOUT=16, engine never ready -> eng_flush pulse 16 cycles after LAUNCH; rsp_timeout=1, fields 0; no RELEASE pulse. Ready arriving on the timeout cycle -> normal response, no flush.
- rsp_ready low 10 cycles -> response fields stable; no new grant despite pending req_valid; grant occurs in the IDLE cycle after RELEASE.
- rst asserted mid-WAIT -> outputs 0 immediately (asynchronous), pointer=1, next request from requester 0 granted.
